parking_request_queue: RTL
==========================

Name: parking_request_queue

Overview:
- Front-end stage directly upstream of the parking_lot_top elevator controller.
- Captures single-cycle entry/exit requests and leakage events, validates them and buffers them in order.
- Presents one pending job at a time on the todo_* interface; the controller consumes it through a pop handshake.
- Leakage relocation jobs take priority over all queued entry/exit jobs.

Parameters:
- DEPTH, 8, number of entry/exit request slots (power of two, 2..16).
- DROP_W, 8, width of the saturating dropped-request counter.

Ports:
- clock  in  1  system clock, rising-edge active.
- reset  in  1  synchronous, active-high reset.
- license_plate  in  16  four BCD digits, [15:12] is the most significant digit.
- in_mode  in  1  one-cycle pulse: car entering.
- out_mode  in  1  one-cycle pulse: car leaving.
- leakage  in  1  level: a leak is active.
- leakage_floor  in  3  floor of the active leak, 1..7.
- req_pop  in  1  controller accepts the current head job.
- todo_exists  out  1  a head job is valid.
- todo_in  out  1  head job is an entry.
- todo_out  out  1  head job is an exit.
- todo_leak_move  out  1  head job is a leak relocation.
- todo_license_plate  out  16  plate of the head job; 0 for a leak job.
- todo_floor  out  3  leak floor for a leak job; 0 otherwise.
- queue_count  out  $clog2(DEPTH)+1  number of occupied entry/exit slots.
- req_error  out  1  one-cycle pulse: request rejected because it is invalid.
- overflow  out  1  one-cycle pulse: valid request dropped because the queue is full.
- drop_count  out  DROP_W  total dropped requests; saturates at all-ones.

Behaviour:
- Reset: all outputs 0, FIFO empty, leak_pending=0, leak_d=0, floor_d=0. Reset mid-operation discards all queued jobs; the pop and push in that same cycle are ignored.
- Request sampling: in_mode or out_mode is sampled at the rising edge.
- Valid request: exactly one of in_mode/out_mode is 1, every nibble of license_plate is <=9, and the plate is nonzero.
- Invalid request: req_error=1 on the next cycle; nothing is pushed.
- Push: a valid request is written to the FIFO tail as {kind, plate}.
- Latency: if the queue was empty and no leak is pending, the job appears at the head (todo_exists=1) on the cycle after the sampling edge. There is no combinational input-to-output path.
- Head selection:
  - leak_pending=1: head is the leak job. todo_leak_move=1, todo_floor=captured floor, todo_in=0, todo_out=0, plate=0.
  - Otherwise, FIFO not empty: head is the oldest FIFO entry.
  - Otherwise: todo_exists=0 and every todo_* output is 0.
- Pop: applies when req_pop=1 and todo_exists=1 at an edge. It removes the currently displayed head (leak job or FIFO head). req_pop while todo_exists=0 is ignored.
- Full FIFO:
  - Push with no FIFO pop in the same cycle: request dropped, overflow=1 for one cycle, drop_count increments (saturating).
  - Push with a simultaneous FIFO pop: accepted; count is unchanged.
- Empty FIFO with simultaneous push and pop: a pop cannot target the new entry; it reaches the head next cycle.
- Leak event detection: leakage=1 and (leak_d=0 or leakage_floor != floor_d). leak_d and floor_d register leakage and leakage_floor every cycle.
- Leak event effect: leak_pending <= 1 and the floor is captured. An event in the same cycle as a leak pop wins: pending stays 1 with the new floor.
- Leak cleared: leakage=0 clears leak_pending on the next edge even if the job was not popped.
- Ordering: FIFO contents are never reordered or altered by leak events.
- queue_count counts FIFO slots only and excludes the leak job.

Decomposition:
- Package parking_pkg:
  - PLATE_W=16, FLOOR_W=3.
  - Request kind encoding: REQ_NONE=2'b00, REQ_IN=2'b01, REQ_OUT=2'b10, REQ_LEAK=2'b11.
  - Function bcd_plate_valid (returns true when every nibble is <=9 and the plate is nonzero).
- Sub-module request_fifo: synchronous FIFO with parameter DEPTH and 18-bit data, push/pop/full/empty/count, read-first on simultaneous push and pop.
- All validation, leak-priority logic and drop counting live in the top module.

Test Plan:
- Entry pulse: in_mode=1, plate 0x9423 for 1 cycle, queue empty -> next cycle todo_exists=1, todo_in=1, todo_license_plate=0x9423, queue_count=1. req_pop -> following cycle todo_exists=0.
- Fill and overflow: push 8 valid entries, then a 9th with no pop -> overflow pulses once, drop_count=1, queue_count stays 8. 9th push with req_pop=1 -> accepted, drop_count unchanged.
- Leak priority: FIFO holds in-job 0x8754, then leakage=1 with floor=3 ->
  - Next cycle head is todo_leak_move=1, todo_floor=3.
  - After pop, head is todo_in=1, plate 0x8754.
  - Floor changed to 5 while leakage stays 1 -> new leak job with floor 5.
- Invalid input:
  - Plate 0x94A3 with in_mode -> req_error=1, queue_count=0.
  - in_mode=out_mode=1 with plate 0x1423 -> req_error=1.
  - Plate 0x0000 -> req_error=1.
- Leak clear: leakage pulses high 2 cycles, no pop -> leak job visible, then gone 1 cycle after leakage=0; FIFO head intact.
- Reset mid-operation: 3 entries queued plus a pending leak, reset=1 for 1 cycle -> all outputs 0, drop_count=0. Next push appears as head after 1 cycle.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking request front-end.
package parking_pkg;

  localparam int unsigned PLATE_W = 16;
  localparam int unsigned FLOOR_W = 3;
  localparam int unsigned DIGITS  = PLATE_W / 4;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_IN   = 2'b01,
    REQ_OUT  = 2'b10,
    REQ_LEAK = 2'b11
  } req_kind_t;

  typedef struct packed {
    req_kind_t            kind;
    logic [PLATE_W-1:0]   plate;
  } req_t;

  // True when every BCD digit is 0..9 and the plate is not all zeros.
  function automatic logic bcd_plate_valid(input logic [PLATE_W-1:0] plate);
    logic ok;
    ok = (plate != '0);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (plate[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/parking_request_queue_fifo.sv
// Ordered store for entry/exit jobs; head is read before a same-cycle write lands.
module request_fifo
  import parking_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  req_t                     push_data,
  input  logic                     pop,
  output req_t                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  req_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/parking_request_queue.sv
// Validates entry/exit/leak requests, queues them in order and presents one head job
// to the elevator controller, with leak relocation taking priority.
module parking_request_queue
  import parking_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [PLATE_W-1:0]       license_plate,
  input  logic                     in_mode,
  input  logic                     out_mode,
  input  logic                     leakage,
  input  logic [FLOOR_W-1:0]       leakage_floor,
  input  logic                     req_pop,
  output logic                     todo_exists,
  output logic                     todo_in,
  output logic                     todo_out,
  output logic                     todo_leak_move,
  output logic [PLATE_W-1:0]       todo_license_plate,
  output logic [FLOOR_W-1:0]       todo_floor,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     req_error,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  req_t                 push_data;
  req_t                 fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 req_any;
  logic                 req_valid;
  logic                 leak_event;
  logic                 leak_pop;
  logic                 leak_pending;
  logic [FLOOR_W-1:0]   leak_floor;
  logic                 leak_d;
  logic [FLOOR_W-1:0]   floor_d;

  assign req_any         = in_mode | out_mode;
  assign req_valid       = (in_mode ^ out_mode) & bcd_plate_valid(license_plate);
  assign push_data.kind  = in_mode ? REQ_IN : REQ_OUT;
  assign push_data.plate = license_plate;

  // The leak job shadows the FIFO head, so a pop only reaches the FIFO without one.
  assign leak_pop   = req_pop & leak_pending;
  assign fifo_pop   = req_pop & todo_exists & ~leak_pending;
  assign leak_event = leakage & (~leak_d | (leakage_floor != floor_d));

  request_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (req_valid),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (queue_count)
  );

  // Head job decode from registered state only.
  always_comb begin
    todo_exists        = 1'b0;
    todo_in            = 1'b0;
    todo_out           = 1'b0;
    todo_leak_move     = 1'b0;
    todo_license_plate = '0;
    todo_floor         = '0;
    if (leak_pending) begin
      todo_exists    = 1'b1;
      todo_leak_move = 1'b1;
      todo_floor     = leak_floor;
    end else if (!fifo_empty) begin
      todo_exists        = 1'b1;
      todo_in            = (fifo_head.kind == REQ_IN);
      todo_out           = (fifo_head.kind == REQ_OUT);
      todo_license_plate = fifo_head.plate;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_error    <= 1'b0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      leak_pending <= 1'b0;
      leak_floor   <= '0;
      leak_d       <= 1'b0;
      floor_d      <= '0;
    end else begin
      req_error <= req_any & ~req_valid;
      overflow  <= req_valid & fifo_full & ~fifo_pop;
      if (req_valid && fifo_full && !fifo_pop && (drop_count != '1)) begin
        drop_count <= drop_count + DROP_W'(1);
      end
      leak_d  <= leakage;
      floor_d <= leakage_floor;
      if (leak_event) begin
        leak_pending <= 1'b1;
        leak_floor   <= leakage_floor;
      end else if (!leakage || leak_pop) begin
        leak_pending <= 1'b0;
      end
    end
  end

endmodule
